// File: rtl/avalon_mm_ddr_responder.sv
// Avalon-MM agent standing in for the DDR EMIF user port, backed by on-chip RAM.
// Optional pseudo-random waitrequest injection is enabled with `define AMM_RESP_STALL_EN.
module avalon_mm_ddr_responder #(
    parameter int ADDR_W          = 25,
    parameter int DATA_W          = 256,
    parameter int BURST_W         = 7,
    parameter int MEM_AW          = 10,
    parameter int RD_LATENCY      = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                CLK_I,
    input  logic                RST_NI,
    input  logic [ADDR_W-1:0]   amm_address_0,
    input  logic                amm_read_0,
    input  logic                amm_write_0,
    input  logic [DATA_W-1:0]   amm_writedata_0,
    input  logic [DATA_W/8-1:0] amm_byteenable_0,
    input  logic [BURST_W-1:0]  amm_burstcount_0,
    output logic                amm_ready_0,
    output logic                amm_readdatavalid_0,
    output logic [DATA_W-1:0]   amm_readdata_0,
    output logic                busy_o,
    output logic                err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << MEM_AW;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);

    typedef enum logic {WR_IDLE, WR_BURST} wr_state_t;
    typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

    logic [1:0]              init_reg;
    wr_state_t               wr_state_reg;
    logic [MEM_AW-1:0]       wr_idx_reg;
    logic [BURST_W-1:0]      wr_rem_reg;
    rd_state_t               rd_state_reg;
    logic [MEM_AW-1:0]       rd_idx_reg;
    logic [BURST_W-1:0]      rd_rem_reg;
    logic [PTR_W:0]          wptr_reg;
    logic [PTR_W:0]          rptr_reg;
    logic [RD_LATENCY-1:0]   pipe_v_reg;
    logic                    err_reg;

    logic [MEM_AW-1:0]       fifo_idx [0:MAX_OUTSTANDING-1];
    logic [BURST_W-1:0]      fifo_bc  [0:MAX_OUTSTANDING-1];
    logic [DATA_W-1:0]       mem      [0:DEPTH-1];
    logic [DATA_W-1:0]       ram_q_reg;
    logic [DATA_W-1:0]       pipe_d_reg [1:RD_LATENCY-1];

    logic [PTR_W:0]          fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    stall;
    logic                    ready_raw;
    logic                    rd_fire;
    logic                    wr_fire;
    logic                    rd_pop;
    logic                    rd_issue;
    logic                    proto_err;
    logic [MEM_AW-1:0]       wr_beat_idx;
    logic [MEM_AW-1:0]       rd_issue_idx;
    logic [BURST_W-1:0]      bc_eff;
    logic [MEM_AW-1:0]       head_idx;
    logic [BURST_W-1:0]      head_bc;

`ifdef AMM_RESP_STALL_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign stall = (lfsr_reg[2:0] == 3'b000);
`else
    assign stall = 1'b0;
`endif

    assign fifo_count = wptr_reg - rptr_reg;
    assign fifo_empty = (wptr_reg == rptr_reg);
    assign fifo_full  = (fifo_count == (PTR_W+1)'(MAX_OUTSTANDING));
    assign head_idx   = fifo_idx[rptr_reg[PTR_W-1:0]];
    assign head_bc    = fifo_bc[rptr_reg[PTR_W-1:0]];

    // Writes are held off until every queued read has sampled the RAM.
    always_comb begin
        ready_raw = 1'b1;
        if (wr_state_reg == WR_IDLE) begin
            if (amm_read_0) begin
                ready_raw = !fifo_full;
            end else if (amm_write_0) begin
                ready_raw = fifo_empty && (rd_state_reg == RD_IDLE);
            end
        end
    end

    assign amm_ready_0  = init_reg[1] && !stall && ready_raw;
    assign rd_fire      = amm_read_0 && amm_ready_0 && (wr_state_reg == WR_IDLE);
    assign wr_fire      = amm_write_0 && amm_ready_0 && ((wr_state_reg == WR_BURST) || !amm_read_0);
    assign proto_err    = amm_read_0 && amm_ready_0 && (amm_write_0 || (wr_state_reg == WR_BURST));
    assign wr_beat_idx  = (wr_state_reg == WR_BURST) ? wr_idx_reg : amm_address_0[MEM_AW-1:0];
    assign bc_eff       = (amm_burstcount_0 == '0) ? BURST_W'(1) : amm_burstcount_0;
    assign rd_pop       = (rd_state_reg == RD_IDLE) && !fifo_empty;
    assign rd_issue     = rd_pop || (rd_state_reg == RD_BURST);
    assign rd_issue_idx = rd_pop ? head_idx : rd_idx_reg;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            init_reg     <= 2'b00;
            wr_state_reg <= WR_IDLE;
            wr_idx_reg   <= '0;
            wr_rem_reg   <= '0;
            rd_state_reg <= RD_IDLE;
            rd_idx_reg   <= '0;
            rd_rem_reg   <= '0;
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            pipe_v_reg   <= '0;
            err_reg      <= 1'b0;
        end else begin
            init_reg <= {init_reg[0], 1'b1};

            if (proto_err) begin
                err_reg <= 1'b1;
            end

            case (wr_state_reg)
                WR_IDLE: begin
                    if (wr_fire && (bc_eff > BURST_W'(1))) begin
                        wr_idx_reg   <= wr_beat_idx + 1'b1;
                        wr_rem_reg   <= bc_eff - 1'b1;
                        wr_state_reg <= WR_BURST;
                    end
                end
                WR_BURST: begin
                    if (wr_fire) begin
                        wr_idx_reg <= wr_idx_reg + 1'b1;
                        wr_rem_reg <= wr_rem_reg - 1'b1;
                        if (wr_rem_reg == BURST_W'(1)) begin
                            wr_state_reg <= WR_IDLE;
                        end
                    end
                end
                default: wr_state_reg <= WR_IDLE;
            endcase

            if (rd_fire) begin
                wptr_reg <= wptr_reg + 1'b1;
            end

            case (rd_state_reg)
                RD_IDLE: begin
                    if (rd_pop) begin
                        rptr_reg   <= rptr_reg + 1'b1;
                        rd_idx_reg <= head_idx + 1'b1;
                        if (head_bc > BURST_W'(1)) begin
                            rd_rem_reg   <= head_bc - 1'b1;
                            rd_state_reg <= RD_BURST;
                        end
                    end
                end
                RD_BURST: begin
                    rd_idx_reg <= rd_idx_reg + 1'b1;
                    rd_rem_reg <= rd_rem_reg - 1'b1;
                    if (rd_rem_reg == BURST_W'(1)) begin
                        rd_state_reg <= RD_IDLE;
                    end
                end
                default: rd_state_reg <= RD_IDLE;
            endcase

            pipe_v_reg <= {pipe_v_reg[RD_LATENCY-2:0], rd_issue};
        end
    end

    // Command FIFO payload: burstcount stored already normalised (0 -> 1).
    always_ff @(posedge CLK_I) begin
        if (rd_fire) begin
            fifo_idx[wptr_reg[PTR_W-1:0]] <= amm_address_0[MEM_AW-1:0];
            fifo_bc[wptr_reg[PTR_W-1:0]]  <= bc_eff;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (wr_fire) begin
            for (int b = 0; b < BE_W; b++) begin
                if (amm_byteenable_0[b]) begin
                    mem[wr_beat_idx][b*8 +: 8] <= amm_writedata_0[b*8 +: 8];
                end
            end
        end
        if (rd_issue) begin
            ram_q_reg <= mem[rd_issue_idx];
        end
    end

    always_ff @(posedge CLK_I) begin
        pipe_d_reg[1] <= ram_q_reg;
        for (int i = 2; i < RD_LATENCY; i++) begin
            pipe_d_reg[i] <= pipe_d_reg[i-1];
        end
    end

    assign amm_readdatavalid_0 = pipe_v_reg[RD_LATENCY-1];
    assign amm_readdata_0      = pipe_v_reg[RD_LATENCY-1] ? pipe_d_reg[RD_LATENCY-1] : '0;
    assign err_o               = err_reg;
    assign busy_o              = (wr_state_reg != WR_IDLE) || (rd_state_reg != RD_IDLE) ||
                                 !fifo_empty || (|pipe_v_reg);

endmodule

// File: tb/tb_avalon_mm_ddr_responder.sv
// Directed bench for avalon_mm_ddr_responder: writes, bursts, byte enables,
// FIFO back-pressure, index wrap, protocol error and reset during a read.
module tb_avalon_mm_ddr_responder;

    logic         CLK_I = 1'b0;
    logic         RST_NI = 1'b0;
    logic [24:0]  amm_address_0 = '0;
    logic         amm_read_0 = 1'b0;
    logic         amm_write_0 = 1'b0;
    logic [255:0] amm_writedata_0 = '0;
    logic [31:0]  amm_byteenable_0 = '0;
    logic [6:0]   amm_burstcount_0 = '0;
    logic         amm_ready_0;
    logic         amm_readdatavalid_0;
    logic [255:0] amm_readdata_0;
    logic         busy_o;
    logic         err_o;

    avalon_mm_ddr_responder dut (
        .CLK_I               (CLK_I),
        .RST_NI              (RST_NI),
        .amm_address_0       (amm_address_0),
        .amm_read_0          (amm_read_0),
        .amm_write_0         (amm_write_0),
        .amm_writedata_0     (amm_writedata_0),
        .amm_byteenable_0    (amm_byteenable_0),
        .amm_burstcount_0    (amm_burstcount_0),
        .amm_ready_0         (amm_ready_0),
        .amm_readdatavalid_0 (amm_readdatavalid_0),
        .amm_readdata_0      (amm_readdata_0),
        .busy_o              (busy_o),
        .err_o               (err_o)
    );

    always #5 CLK_I = ~CLK_I;

    int cyc = 0;
    always @(posedge CLK_I) cyc++;

    int checks = 0;
    int errors = 0;
    logic [255:0] rx_q[$];
    int           rx_cyc_q[$];

    always @(negedge CLK_I) begin
        if (amm_readdatavalid_0) begin
            rx_q.push_back(amm_readdata_0);
            rx_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [255:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request from a negedge and holds it until accepted (bounded).
    task automatic req(input logic rd, input logic wr, input logic [24:0] addr,
                       input logic [255:0] data, input logic [31:0] be,
                       input logic [6:0] bc, output int acc);
        int n;
        @(negedge CLK_I);
        amm_read_0       = rd;
        amm_write_0      = wr;
        amm_address_0    = addr;
        amm_writedata_0  = data;
        amm_byteenable_0 = be;
        amm_burstcount_0 = bc;
        #1;
        n = 0;
        while (!amm_ready_0 && n < 300) begin
            @(negedge CLK_I);
            #1;
            n++;
        end
        if (!amm_ready_0) begin
            chk("ready_timeout", 256'(amm_ready_0), 256'(1));
            acc = -1;
        end else begin
            @(posedge CLK_I);
            #1;
            acc = cyc;
        end
        amm_read_0  = 1'b0;
        amm_write_0 = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int t;
        t = 0;
        while (rx_q.size() < n && t < 400) begin
            @(negedge CLK_I);
            #1;
            t++;
        end
        chk("rx_count", 256'(rx_q.size()), 256'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int acc0;
        logic [31:0] be_all;
        be_all = 32'hFFFF_FFFF;

        // Reset state
        #12;
        chk("rst_ready", 256'(amm_ready_0), 256'(0));
        chk("rst_valid", 256'(amm_readdatavalid_0), 256'(0));
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_err", 256'(err_o), 256'(0));
        chk("rst_rdata", amm_readdata_0, 256'(0));
        @(negedge CLK_I);
        RST_NI = 1'b1;
        @(negedge CLK_I);
        chk("ready_edge1", 256'(amm_ready_0), 256'(0));
        @(negedge CLK_I);
        chk("ready_edge2", 256'(amm_ready_0), 256'(1));

        // 1: single write then read, latency check
        req(1'b0, 1'b1, 25'h10, rep(8'hA5), be_all, 7'd1, acc);
        rx_q.delete(); rx_cyc_q.delete();
        req(1'b1, 1'b0, 25'h10, '0, '0, 7'd1, acc);
        wait_rx(1);
        chk("t1_data", rx_q[0], rep(8'hA5));
        chk("t1_latency", 256'(rx_cyc_q[0] - acc), 256'(4));

        // 2: 4-beat write burst with an idle gap, then 4-beat read
        req(1'b0, 1'b1, 25'h20, rep(8'hD0), be_all, 7'd4, acc);
        req(1'b0, 1'b1, 25'h0,  rep(8'hD1), be_all, 7'd4, acc);
        @(negedge CLK_I);
        #1;
        chk("t2_busy_gap", 256'(busy_o), 256'(1));
        req(1'b0, 1'b1, 25'h0, rep(8'hD2), be_all, 7'd4, acc);
        req(1'b0, 1'b1, 25'h0, rep(8'hD3), be_all, 7'd4, acc);
        rx_q.delete(); rx_cyc_q.delete();
        req(1'b1, 1'b0, 25'h20, '0, '0, 7'd4, acc);
        wait_rx(4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_data%0d", i), rx_q[i], rep(8'hD0 + 8'(i)));
            chk($sformatf("t2_b2b%0d", i), 256'(rx_cyc_q[i]), 256'(acc + 4 + i));
        end

        // 3: partial byte enable over an all-FF word
        req(1'b0, 1'b1, 25'h30, rep(8'hFF), be_all, 7'd1, acc);
        req(1'b0, 1'b1, 25'h30, '0, 32'h0000_000F, 7'd1, acc);
        rx_q.delete(); rx_cyc_q.delete();
        req(1'b1, 1'b0, 25'h30, '0, '0, 7'd1, acc);
        wait_rx(1);
        chk("t3_be", rx_q[0], {{28{8'hFF}}, 32'h0});

        // 4: nine single reads back-to-back, returned in order
        for (int i = 0; i < 9; i++) begin
            req(1'b0, 1'b1, 25'h40, rep(8'h40 + 8'(i)), be_all, 7'd9, acc);
        end
        rx_q.delete(); rx_cyc_q.delete();
        for (int i = 0; i < 9; i++) begin
            req(1'b1, 1'b0, 25'h40 + 25'(i), '0, '0, 7'd1, acc);
        end
        wait_rx(9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t4_order%0d", i), rx_q[i], rep(8'h40 + 8'(i)));
        end
        repeat (6) @(negedge CLK_I);
        #1;
        chk("t4_idle_busy", 256'(busy_o), 256'(0));

        // 4b: long bursts fill the command FIFO and stall further reads
        rx_q.delete(); rx_cyc_q.delete();
        for (int i = 0; i < 9; i++) begin
            req(1'b1, 1'b0, 25'h100, '0, '0, 7'd16, acc);
        end
        amm_read_0 = 1'b1;
        #1;
        chk("t4_full_ready", 256'(amm_ready_0), 256'(0));
        chk("t4_full_busy", 256'(busy_o), 256'(1));
        amm_read_0 = 1'b0;
        req(1'b1, 1'b0, 25'h100, '0, '0, 7'd16, acc);
        wait_rx(160);

        // 5: burst across the top of the RAM wraps to index 0 (upper address bits alias)
        req(1'b0, 1'b1, 25'h10003FF, rep(8'hE1), be_all, 7'd2, acc);
        req(1'b0, 1'b1, 25'h0,       rep(8'hE2), be_all, 7'd2, acc);
        rx_q.delete(); rx_cyc_q.delete();
        req(1'b1, 1'b0, 25'h0,   '0, '0, 7'd1, acc);
        req(1'b1, 1'b0, 25'h3FF, '0, '0, 7'd1, acc);
        wait_rx(2);
        chk("t5_wrap0", rx_q[0], rep(8'hE2));
        chk("t5_top", rx_q[1], rep(8'hE1));

        // 6: simultaneous read and write -> read wins, error flagged
        rx_q.delete(); rx_cyc_q.delete();
        req(1'b1, 1'b1, 25'h10, rep(8'h77), be_all, 7'd1, acc);
        chk("t6_err", 256'(err_o), 256'(1));
        wait_rx(1);
        chk("t6_rdata", rx_q[0], rep(8'hA5));

        // 6b: reset in the middle of a 4-beat read drops it
        repeat (6) @(negedge CLK_I);
        rx_q.delete(); rx_cyc_q.delete();
        req(1'b1, 1'b0, 25'h20, '0, '0, 7'd4, acc0);
        @(posedge CLK_I);
        @(negedge CLK_I);
        RST_NI = 1'b0;
        #1;
        chk("t6_rst_err", 256'(err_o), 256'(0));
        chk("t6_rst_valid", 256'(amm_readdatavalid_0), 256'(0));
        chk("t6_rst_busy", 256'(busy_o), 256'(0));
        repeat (3) @(negedge CLK_I);
        RST_NI = 1'b1;
        repeat (10) @(negedge CLK_I);
        #1;
        chk("t6_no_valids", 256'(rx_q.size()), 256'(0));
        chk("t6_ready_back", 256'(amm_ready_0), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
